// File: rtl/uart_disp_cmd_ctrl_pkg.sv
// Shared types and constants for the UART-to-display command sequencer.
package uart_disp_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_CMD,
    GET_ARG,
    GET_CHK,
    APPLY
  } state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [7:0] chk;
  } frame_t;

  localparam logic [3:0] CMD_DIGIT         = 4'h1;
  localparam logic [7:0] CMD_DP            = 8'h20;
  localparam logic [7:0] CMD_BLANK         = 8'h30;
  localparam logic [7:0] CMD_CLEAR         = 8'h40;
  localparam logic [7:0] ACK               = 8'h06;
  localparam logic [7:0] NAK               = 8'h15;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Digit writes are legal only for digits that physically exist.
  function automatic logic cmdLegal(input logic [7:0] cmd, input int unsigned nDigits);
    return ((cmd[7:4] == CMD_DIGIT) && (32'(cmd[3:0]) < nDigits)) ||
           (cmd == CMD_DP) || (cmd == CMD_BLANK) || (cmd == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/uart_disp_cmd_ctrl_if.sv
// Byte-receive and display-configuration bundle of the command sequencer.
// ECHO_STATUS_EN adds the ACK/NAK transmit strobe and byte.
interface uart_disp_cmd_ctrl_if #(
  parameter int unsigned NDIGITS = 4
);
  logic [7:0]           rxData;
  logic                 rxDone;
  logic [4*NDIGITS-1:0] digits;
  logic [NDIGITS-1:0]   dpMask;
  logic                 blank;
  logic                 frameOk;
  logic                 frameErr;
`ifdef ECHO_STATUS_EN
  logic [7:0]           txData;
  logic                 txStart;
`endif

  modport master (
    output rxData, rxDone,
    input  digits, dpMask, blank, frameOk, frameErr
`ifdef ECHO_STATUS_EN
    , input txData, txStart
`endif
  );

  modport slave (
    input  rxData, rxDone,
    output digits, dpMask, blank, frameOk, frameErr
`ifdef ECHO_STATUS_EN
    , output txData, txStart
`endif
  );
endinterface

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT       = 1_000_000,
  parameter int unsigned NBITS_TIMEOUT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [NBITS_TIMEOUT-1:0] count;
  logic [NBITS_TIMEOUT-1:0] cntNext;

  assign cntNext = count + 1'b1;

  // expired is registered so it is high exactly while count == TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      count   <= cntNext;
      expired <= (cntNext == NBITS_TIMEOUT'(TIMEOUT));
    end
  end

endmodule

// File: rtl/uart_disp_cmd_ctrl.sv
// Parses SYNC/CMD/ARG/CHK byte frames from the UART receiver and updates the
// 7-segment display configuration. Optional ACK/NAK echo: ECHO_STATUS_EN.
module uart_disp_cmd_ctrl
  import uart_disp_cmd_ctrl_pkg::*;
#(
  parameter int unsigned NDIGITS       = 4,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT       = 1_000_000,
  parameter int unsigned NBITS_TIMEOUT = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_disp_cmd_ctrl_if.slave  bus
);

  state_t               state, stateNext;
  frame_t               frame, frameNext;
  logic [4*NDIGITS-1:0] digitsQ, digitsNext;
  logic [NDIGITS-1:0]   dpQ, dpNext;
  logic                 blankQ, blankNext;
  logic                 okQ, okNext;
  logic                 errQ, errNext;
  logic                 inFrame;
  logic                 tmrClear;
  logic                 tmrExpired;
`ifdef ECHO_STATUS_EN
  logic [7:0]           txDataQ, txDataNext;
  logic                 txStartQ, txStartNext;
`endif

  assign inFrame  = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
  // A received byte always restarts the watchdog, even in its expiry cycle.
  assign tmrClear = bus.rxDone || !inFrame;

  cmd_timeout_timer #(
    .TIMEOUT       (TIMEOUT),
    .NBITS_TIMEOUT (NBITS_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmrClear),
    .enable  (inFrame),
    .expired (tmrExpired)
  );

  always_comb begin
    stateNext  = state;
    frameNext  = frame;
    digitsNext = digitsQ;
    dpNext     = dpQ;
    blankNext  = blankQ;
    okNext     = 1'b0;
    errNext    = 1'b0;

    case (state)
      WAIT_SYNC: begin
        if (bus.rxDone && (bus.rxData == SYNC_BYTE)) stateNext = GET_CMD;
      end
      GET_CMD: begin
        if (bus.rxDone) begin
          frameNext.cmd = bus.rxData;
          stateNext     = GET_ARG;
        end else if (tmrExpired) begin
          errNext   = 1'b1;
          stateNext = WAIT_SYNC;
        end
      end
      GET_ARG: begin
        if (bus.rxDone) begin
          frameNext.arg = bus.rxData;
          stateNext     = GET_CHK;
        end else if (tmrExpired) begin
          errNext   = 1'b1;
          stateNext = WAIT_SYNC;
        end
      end
      GET_CHK: begin
        if (bus.rxDone) begin
          frameNext.chk = bus.rxData;
          stateNext     = APPLY;
        end else if (tmrExpired) begin
          errNext   = 1'b1;
          stateNext = WAIT_SYNC;
        end
      end
      APPLY: begin
        stateNext = WAIT_SYNC;
        if ((frame.chk == (SYNC_BYTE ^ frame.cmd ^ frame.arg)) && cmdLegal(frame.cmd, NDIGITS)) begin
          okNext = 1'b1;
          if (frame.cmd[7:4] == CMD_DIGIT) begin
            for (int unsigned i = 0; i < NDIGITS; i++) begin
              if (frame.cmd[3:0] == 4'(i)) digitsNext[4*i +: 4] = frame.arg[3:0];
            end
          end else if (frame.cmd == CMD_DP) begin
            dpNext = frame.arg[NDIGITS-1:0];
          end else if (frame.cmd == CMD_BLANK) begin
            blankNext = frame.arg[0];
          end else begin
            digitsNext = '0;
            dpNext     = '0;
            blankNext  = 1'b0;
          end
        end else begin
          errNext = 1'b1;
        end
      end
      default: stateNext = WAIT_SYNC;
    endcase
  end

`ifdef ECHO_STATUS_EN
  always_comb begin
    txStartNext = okNext || errNext;
    txDataNext  = txDataQ;
    if (okNext)       txDataNext = ACK;
    else if (errNext) txDataNext = NAK;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_SYNC;
      frame   <= '0;
      digitsQ <= '0;
      dpQ     <= '0;
      blankQ  <= 1'b0;
      okQ     <= 1'b0;
      errQ    <= 1'b0;
`ifdef ECHO_STATUS_EN
      txDataQ  <= '0;
      txStartQ <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      frame   <= frameNext;
      digitsQ <= digitsNext;
      dpQ     <= dpNext;
      blankQ  <= blankNext;
      okQ     <= okNext;
      errQ    <= errNext;
`ifdef ECHO_STATUS_EN
      txDataQ  <= txDataNext;
      txStartQ <= txStartNext;
`endif
    end
  end

  assign bus.digits   = digitsQ;
  assign bus.dpMask   = dpQ;
  assign bus.blank    = blankQ;
  assign bus.frameOk  = okQ;
  assign bus.frameErr = errQ;
`ifdef ECHO_STATUS_EN
  assign bus.txData   = txDataQ;
  assign bus.txStart  = txStartQ;
`endif

endmodule
